bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 137 +++++++++++++
 tb/tb_bus_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master (ibus fetch / dbus load-store) arbiter onto one
// downstream port. dbus wins ties; the grant is held until cresp_ok.
// Optional macro BUS_ARB_FAIR_EN adds a 3-bit starvation counter that
// forces an ibus grant after STARVE_LIMIT dbus completions while ibus waits.
module bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    // instruction fetch side
    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_ok,
    output logic [31:0] iresp_data,
    // data side
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_ok,
    output logic [63:0] dresp_data,
    // shared downstream
    output logic        creq_valid,
    output logic        creq_is_write,
    output logic [63:0] creq_addr,
    output logic [2:0]  creq_size,
    output logic [7:0]  creq_strobe,
    output logic [63:0] creq_data,
    input  logic        cresp_ok,
    input  logic [63:0] cresp_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] IGNT = 2'd1;
    localparam logic [1:0] DGNT = 2'd2;

    logic [1:0] state, state_nxt;
    logic       arb_en;
    logic       ibus_first;

    // A new decision is taken when idle or on the completion cycle, so
    // back-to-back grants need no idle cycle in between.
    assign arb_en = (state == IDLE) || cresp_ok;

`ifdef BUS_ARB_FAIR_EN
    logic [2:0] starve_cnt;
    logic [2:0] starve_inc;
    logic       d_done_wait;

    // Count includes the completion happening this cycle, so the grant that
    // follows the STARVE_LIMIT-th dbus completion already goes to ibus.
    assign d_done_wait = (state == DGNT) && cresp_ok && ireq_valid;
    assign starve_inc  = (d_done_wait && (starve_cnt != 3'd7)) ? starve_cnt + 3'd1
                                                                : starve_cnt;
    assign ibus_first  = ireq_valid && (32'(starve_inc) >= 32'(STARVE_LIMIT));

    // Starvation counter: cleared whenever ibus is granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            starve_cnt <= 3'd0;
        else if (arb_en && (state_nxt == IGNT))
            starve_cnt <= 3'd0;
        else
            starve_cnt <= starve_inc;
    end
`else
    logic unused_starve_limit;

    // Strict dbus priority; the limit only matters in the fair build.
    assign ibus_first          = 1'b0;
    assign unused_starve_limit = |STARVE_LIMIT;
`endif

    // Next-state: hold while a transaction is outstanding, else arbitrate.
    always_comb begin
        state_nxt = state;
        if (arb_en) begin
            if (ibus_first)
                state_nxt = IGNT;
            else if (dreq_valid)
                state_nxt = DGNT;
            else if (ireq_valid)
                state_nxt = IGNT;
            else
                state_nxt = IDLE;
        end
    end

    // State register; async reset drops any grant immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Downstream request muxed from the granted side; zero when idle.
    always_comb begin
        creq_valid    = 1'b0;
        creq_is_write = 1'b0;
        creq_addr     = 64'd0;
        creq_size     = 3'd0;
        creq_strobe   = 8'd0;
        creq_data     = 64'd0;
        case (state)
            IGNT: begin
                creq_valid = 1'b1;
                creq_addr  = ireq_addr;
                creq_size  = 3'b010;
            end
            DGNT: begin
                creq_valid    = 1'b1;
                creq_is_write = |dreq_strobe;
                creq_addr     = dreq_addr;
                creq_size     = dreq_size;
                creq_strobe   = dreq_strobe;
                creq_data     = dreq_data;
            end
            default: ;
        endcase
    end

    // Responses: only the granted side sees ok; data is zero outside its pulse
    // so every output reads 0 while idle or held in reset.
    always_comb begin
        iresp_ok   = (state == IGNT) && cresp_ok;
        dresp_ok   = (state == DGNT) && cresp_ok;
        iresp_data = 32'd0;
        dresp_data = 64'd0;
        if (iresp_ok)
            iresp_data = ireq_addr[2] ? cresp_data[63:32] : cresp_data[31:0];
        if (dresp_ok)
            dresp_data = cresp_data;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table-driven cycle vectors plus hand sequences for reset,
// first-grant timing and starvation (expectation depends on BUS_ARB_FAIR_EN).
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_ok;
    logic [31:0] iresp_data;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_ok;
    logic [63:0] dresp_data;
    logic        creq_valid;
    logic        creq_is_write;
    logic [63:0] creq_addr;
    logic [2:0]  creq_size;
    logic [7:0]  creq_strobe;
    logic [63:0] creq_data;
    logic        cresp_ok;
    logic [63:0] cresp_data;

    bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_ok(iresp_ok), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_ok(dresp_ok), .dresp_data(dresp_data),
        .creq_valid(creq_valid), .creq_is_write(creq_is_write),
        .creq_addr(creq_addr), .creq_size(creq_size),
        .creq_strobe(creq_strobe), .creq_data(creq_data),
        .cresp_ok(cresp_ok), .cresp_data(cresp_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // gnt: 0 none, 1 ibus, 2 dbus
    typedef struct {
        logic        iv;
        logic [63:0] ia;
        logic        dv;
        logic [63:0] da;
        logic [2:0]  dsz;
        logic [7:0]  dst;
        logic [63:0] dd;
        logic        ok;
        logic [63:0] cd;
        logic [1:0]  e_gnt;
        logic        e_wr;
        logic [63:0] e_addr;
        logic [2:0]  e_sz;
        logic [7:0]  e_st;
        logic [63:0] e_dat;
        logic        e_iok;
        logic [31:0] e_idat;
        logic        e_dok;
    } vec_t;

    function automatic vec_t mk(
        input logic iv, input logic [63:0] ia,
        input logic dv, input logic [63:0] da, input logic [2:0] dsz,
        input logic [7:0] dst, input logic [63:0] dd,
        input logic ok, input logic [63:0] cd,
        input logic [1:0] e_gnt, input logic e_wr, input logic [63:0] e_addr,
        input logic [2:0] e_sz, input logic [7:0] e_st, input logic [63:0] e_dat,
        input logic e_iok, input logic [31:0] e_idat, input logic e_dok);
        vec_t v;
        v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.dsz = dsz; v.dst = dst;
        v.dd = dd; v.ok = ok; v.cd = cd; v.e_gnt = e_gnt; v.e_wr = e_wr;
        v.e_addr = e_addr; v.e_sz = e_sz; v.e_st = e_st; v.e_dat = e_dat;
        v.e_iok = e_iok; v.e_idat = e_idat; v.e_dok = e_dok;
        return v;
    endfunction

    vec_t vecs[17];

    task automatic drive(input logic iv, input logic [63:0] ia, input logic dv,
                         input logic [63:0] da, input logic [2:0] dsz,
                         input logic [7:0] dst, input logic [63:0] dd,
                         input logic ok, input logic [63:0] cd);
        ireq_valid = iv; ireq_addr = ia; dreq_valid = dv; dreq_addr = da;
        dreq_size = dsz; dreq_strobe = dst; dreq_data = dd;
        cresp_ok = ok; cresp_data = cd;
    endtask

    initial begin
        // ---------------- stimulus table (one entry per clock) -------------
        // fetch at 0x8000_0004, ok on 2nd grant cycle, back-to-back refetch,
        // valid dropped mid-grant, then completion with addr[2]=0
        vecs[0]  = mk(1'b1, 64'h8000_0004, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 64'h0,
                      2'd0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 32'h0, 1'b0);
        vecs[1]  = mk(1'b1, 64'h8000_0004, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 64'h0,
                      2'd1, 1'b0, 64'h8000_0004, 3'b010, 8'h00, 64'h0, 1'b0, 32'h0, 1'b0);
        vecs[2]  = mk(1'b1, 64'h8000_0004, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b1, 64'h1111_2222_3333_4444,
                      2'd1, 1'b0, 64'h8000_0004, 3'b010, 8'h00, 64'h0, 1'b1, 32'h1111_2222, 1'b0);
        vecs[3]  = mk(1'b0, 64'h8000_0000, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 64'h0,
                      2'd1, 1'b0, 64'h8000_0000, 3'b010, 8'h00, 64'h0, 1'b0, 32'h0, 1'b0);
        vecs[4]  = mk(1'b0, 64'h8000_0000, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD,
                      2'd1, 1'b0, 64'h8000_0000, 3'b010, 8'h00, 64'h0, 1'b1, 32'hCCCC_DDDD, 1'b0);
        vecs[5]  = mk(1'b0, 64'h0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 64'h0,
                      2'd0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 32'h0, 1'b0);
        // dbus write of 0xDEAD_BEEF, strobe 0xFF
        vecs[6]  = mk(1'b0, 64'h0, 1'b1, 64'h1000, 3'd3, 8'hFF, 64'hDEAD_BEEF, 1'b0, 64'h0,
                      2'd0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 32'h0, 1'b0);
        vecs[7]  = mk(1'b0, 64'h0, 1'b1, 64'h1000, 3'd3, 8'hFF, 64'hDEAD_BEEF, 1'b0, 64'h0,
                      2'd2, 1'b1, 64'h1000, 3'd3, 8'hFF, 64'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
        vecs[8]  = mk(1'b0, 64'h0, 1'b0, 64'h1000, 3'd3, 8'hFF, 64'hDEAD_BEEF, 1'b1, 64'h0123_4567_89AB_CDEF,
                      2'd2, 1'b1, 64'h1000, 3'd3, 8'hFF, 64'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        vecs[9]  = mk(1'b0, 64'h0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 64'h0,
                      2'd0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 32'h0, 1'b0);
        // simultaneous requests: dbus read first, held while ibus waits,
        // then ibus on the dbus completion cycle with no idle gap
        vecs[10] = mk(1'b1, 64'h2000, 1'b1, 64'h3000, 3'd3, 8'h00, 64'h0, 1'b0, 64'h0,
                      2'd0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 32'h0, 1'b0);
        vecs[11] = mk(1'b1, 64'h2000, 1'b1, 64'h3000, 3'd3, 8'h00, 64'h0, 1'b0, 64'h0,
                      2'd2, 1'b0, 64'h3000, 3'd3, 8'h00, 64'h0, 1'b0, 32'h0, 1'b0);
        vecs[12] = mk(1'b1, 64'h2000, 1'b1, 64'h3000, 3'd3, 8'h00, 64'h0, 1'b0, 64'h0,
                      2'd2, 1'b0, 64'h3000, 3'd3, 8'h00, 64'h0, 1'b0, 32'h0, 1'b0);
        vecs[13] = mk(1'b1, 64'h2000, 1'b0, 64'h3000, 3'd3, 8'h00, 64'h0, 1'b1, 64'h99,
                      2'd2, 1'b0, 64'h3000, 3'd3, 8'h00, 64'h0, 1'b0, 32'h0, 1'b1);
        vecs[14] = mk(1'b1, 64'h2000, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 64'h0,
                      2'd1, 1'b0, 64'h2000, 3'b010, 8'h00, 64'h0, 1'b0, 32'h0, 1'b0);
        vecs[15] = mk(1'b0, 64'h2000, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b1, 64'h7777_8888_0000_0001,
                      2'd1, 1'b0, 64'h2000, 3'b010, 8'h00, 64'h0, 1'b1, 32'h0000_0001, 1'b0);
        vecs[16] = mk(1'b0, 64'h0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 64'h0,
                      2'd0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 32'h0, 1'b0);

        // ---------------- reset: outputs 0 even with requests pending ------
        reset = 1'b0;
        drive(1'b1, 64'h8000_0004, 1'b1, 64'h10, 3'd3, 8'hFF, 64'h5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (3) begin
            @(negedge clk);
            chk("rst_creq_valid", 64'(creq_valid), 64'h0);
            chk("rst_iresp_ok", 64'(iresp_ok), 64'h0);
            chk("rst_dresp_ok", 64'(dresp_ok), 64'h0);
            chk("rst_is_write", 64'(creq_is_write), 64'h0);
            chk("rst_iresp_data", 64'(iresp_data), 64'h0);
            chk("rst_dresp_data", dresp_data, 64'h0);
        end
        drive(1'b0, 64'h0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 64'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        // ---------------- table vectors ------------------------------------
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].iv, vecs[i].ia, vecs[i].dv, vecs[i].da, vecs[i].dsz,
                  vecs[i].dst, vecs[i].dd, vecs[i].ok, vecs[i].cd);
            @(negedge clk);
            chk($sformatf("v%0d_creq_valid", i), 64'(creq_valid), 64'(vecs[i].e_gnt != 2'd0));
            chk($sformatf("v%0d_is_write", i), 64'(creq_is_write), 64'(vecs[i].e_wr));
            chk($sformatf("v%0d_iresp_ok", i), 64'(iresp_ok), 64'(vecs[i].e_iok));
            chk($sformatf("v%0d_dresp_ok", i), 64'(dresp_ok), 64'(vecs[i].e_dok));
            if (vecs[i].e_gnt != 2'd0) begin
                chk($sformatf("v%0d_addr", i), creq_addr, vecs[i].e_addr);
                chk($sformatf("v%0d_size", i), 64'(creq_size), 64'(vecs[i].e_sz));
                chk($sformatf("v%0d_strobe", i), 64'(creq_strobe), 64'(vecs[i].e_st));
            end
            if (vecs[i].e_gnt == 2'd2)
                chk($sformatf("v%0d_creq_data", i), creq_data, vecs[i].e_dat);
            if (vecs[i].e_iok)
                chk($sformatf("v%0d_iresp_data", i), 64'(iresp_data), 64'(vecs[i].e_idat));
            if (vecs[i].e_dok)
                chk($sformatf("v%0d_dresp_data", i), dresp_data, vecs[i].cd);
            @(posedge clk); #1;
        end

        // ---------------- reset mid-grant, first grant after release -------
        drive(1'b1, 64'h4000, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 64'h0);
        @(posedge clk); #2;
        chk("pre_reset_grant", 64'(creq_valid), 64'h1);
        reset = 1'b0;
        #1;
        chk("reset_drops_valid", 64'(creq_valid), 64'h0);
        @(posedge clk); #1;
        chk("held_in_reset", 64'(creq_valid), 64'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("no_grant_before_edge", 64'(creq_valid), 64'h0);
        @(posedge clk); #1;
        chk("grant_after_release", 64'(creq_valid), 64'h1);
        chk("grant_after_release_addr", creq_addr, 64'h4000);
        drive(1'b0, 64'h4000, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b1, 64'h5555_6666_7777_8888);
        #1;
        chk("post_reset_iresp_ok", 64'(iresp_ok), 64'h1);
        chk("post_reset_iresp_data", 64'(iresp_data), 64'h7777_8888);
        @(posedge clk); #1;
        drive(1'b0, 64'h0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 64'h0);
        #1;
        chk("idle_after_completion", 64'(creq_valid), 64'h0);

        // ---------------- starvation: both held, ok every cycle ------------
        drive(1'b1, 64'h1000, 1'b1, 64'hD000, 3'd3, 8'h00, 64'h0, 1'b1, 64'h42);
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("starve_idle", 64'(creq_valid), 64'h0);
            end else begin
                logic [63:0] exp_addr;
`ifdef BUS_ARB_FAIR_EN
                exp_addr = (c % 5 == 0) ? 64'h1000 : 64'hD000;
`else
                exp_addr = 64'hD000;
`endif
                chk($sformatf("starve_c%0d_valid", c), 64'(creq_valid), 64'h1);
                chk($sformatf("starve_c%0d_grant_addr", c), creq_addr, exp_addr);
            end
            @(posedge clk); #1;
        end
        drive(1'b0, 64'h0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b1, 64'h0);
        @(posedge clk); #1;
        cresp_ok = 1'b0;
        @(negedge clk);
        chk("final_idle", 64'(creq_valid), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
